// File: rtl/slice_serial_adder_pkg.sv
// Shared definitions for the slice-serial adder: controller states, slice width
// and a helper that sizes the slice index.
package slice_serial_adder_pkg;

   localparam int unsigned SLICE = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // ceil(log2(n)) bits, kept to at least one bit so a single-slice build still has an index.
   function automatic int unsigned idx_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/slice_serial_adder_slice3.sv
// Combinational 3-bit ripple slice: {co, s} = a + b + ci.
module adder_slice3
   import slice_serial_adder_pkg::*;
(
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             ci,
   output logic [SLICE-1:0] s,
   output logic             co
);

   logic [SLICE:0] total;

   always_comb begin
      total = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
      s     = total[SLICE-1:0];
      co    = total[SLICE];
   end

endmodule

// File: rtl/slice_serial_adder.sv
// Multi-cycle adder: one 3-bit slice adder is time-shared across WIDTH/SLICE
// cycles, with ready/valid handshakes on both the operand and result sides.
module slice_serial_adder
   import slice_serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned SLICE = slice_serial_adder_pkg::SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned KW     = idx_bits(NSLICE);
   localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

   if (SLICE != slice_serial_adder_pkg::SLICE) begin : g_bad_slice
      $error("slice_serial_adder: SLICE must equal the slice adder width");
   end
   if (WIDTH == 0 || (WIDTH % SLICE) != 0) begin : g_bad_width
      $error("slice_serial_adder: WIDTH must be a positive multiple of SLICE");
   end

   state_e           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;

   logic [SLICE-1:0] sl_a, sl_b, sl_s;
   logic             sl_co;

   // Constant-index mux keeps the slice select free of variable part-selects.
   always_comb begin
      sl_a = '0;
      sl_b = '0;
      for (int unsigned i = 0; i < NSLICE; i++) begin
         if (k_q == KW'(i)) begin
            sl_a = a_q[i*SLICE +: SLICE];
            sl_b = b_q[i*SLICE +: SLICE];
         end
      end
   end

   adder_slice3 u_slice (
      .a  (sl_a),
      .b  (sl_b),
      .ci (carry_q),
      .s  (sl_s),
      .co (sl_co)
   );

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_cin;
               sum_d   = '0;
               k_d     = '0;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            for (int unsigned i = 0; i < NSLICE; i++) begin
               if (k_q == KW'(i)) begin
                  sum_d[i*SLICE +: SLICE] = sl_s;
               end
            end
            carry_d = sl_co;
            // Index parks on the last slice rather than wrapping.
            if (k_q == K_LAST) begin
               state_d = ST_DONE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end

         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   assign out_sum  = sum_q;
   assign out_cout = carry_q;

endmodule

// File: tb/tb_slice_serial_adder.sv
// Scoreboard bench for slice_serial_adder: directed corner cases plus random
// operands with random result backpressure, checked against A+B+cin.
module tb_slice_serial_adder;

   localparam int unsigned WIDTH = 12;
   localparam int unsigned SLICE = 3;
   localparam int unsigned NSL   = WIDTH / SLICE;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int unsigned accept_cyc = 0;
   bit          bp_random = 1'b0;
   logic [WIDTH:0] exp_q[$];

   slice_serial_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (bp_random) out_ready = ($urandom_range(0, 3) != 0);
   end

   function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic cin);
      return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   endfunction

   task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: latency, stability under backpressure, and in-order result compare.
   bit             prev_valid = 1'b0;
   bit             pending = 1'b0;
   logic [WIDTH:0] held;
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         pending    = 1'b0;
      end else begin
         if (out_valid && !prev_valid)
            check("latency", (WIDTH+1)'(cyc - accept_cyc), (WIDTH+1)'(NSL));
         if (out_valid && pending)
            check("hold_stable", {out_cout, out_sum}, held);
         if (out_valid)
            check("in_ready_busy", {{WIDTH{1'b0}}, in_ready}, '0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got %h expected none", {out_cout, out_sum});
            end else begin
               check("result", {out_cout, out_sum}, exp_q.pop_front());
            end
         end
         pending    = out_valid && !out_ready;
         held       = {out_cout, out_sum};
         prev_valid = out_valid;
      end
   end

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                       input bit push, input logic [WIDTH:0] exp);
      int unsigned t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
         return;
      end
      @(posedge clk);
      #1;
      in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      if (push) exp_q.push_back(exp);
      in_valid = 1'b0;
      in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_cin = 1'($urandom);
   endtask

   task automatic drain();
      int unsigned t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("drain_empty", (WIDTH+1)'(exp_q.size()), '0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation did not terminate");
   end

   initial begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      int unsigned      t;

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", {{WIDTH{1'b0}}, out_valid}, '0);
      check("rst_in_ready", {{WIDTH{1'b0}}, in_ready}, (WIDTH+1)'(1));
      check("rst_sum_cout", {out_cout, out_sum}, '0);

      send(12'h123, 12'h456, 1'b0, 1'b1, 13'h0579);
      drain();
      send(12'hFFF, 12'h001, 1'b0, 1'b1, 13'h1000);
      drain();
      send(12'h800, 12'h800, 1'b1, 1'b1, 13'h1001);
      drain();

      // Backpressure: result must be held for 10 cycles, then release.
      out_ready = 1'b0;
      send(12'hABC, 12'h321, 1'b1, 1'b1, 13'h0DDE);
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("bp_valid_seen", {{WIDTH{1'b0}}, out_valid}, (WIDTH+1)'(1));
      repeat (10) begin
         @(negedge clk);
         check("bp_valid_held", {{WIDTH{1'b0}}, out_valid}, (WIDTH+1)'(1));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_idle_valid", {{WIDTH{1'b0}}, out_valid}, '0);
      check("bp_idle_ready", {{WIDTH{1'b0}}, in_ready}, (WIDTH+1)'(1));
      drain();

      // Reset in the second RUN cycle discards the operation.
      send(12'h0AB, 12'h0CD, 1'b1, 1'b0, '0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", {{WIDTH{1'b0}}, out_valid}, '0);
      check("midrst_in_ready", {{WIDTH{1'b0}}, in_ready}, (WIDTH+1)'(1));
      check("midrst_cout", {{WIDTH{1'b0}}, out_cout}, '0);
      send(12'h007, 12'h001, 1'b0, 1'b1, 13'h0008);
      drain();

      bp_random = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         rc = 1'($urandom);
         send(ra, rb, rc, 1'b1, ref_add(ra, rb, rc));
      end
      drain();
      bp_random = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
